// File: rtl/dcache_responder_pkg.sv
// Shared geometry, FSM encoding and payload types for the direct-mapped data cache.
package dcache_responder_pkg;

   localparam int unsigned LINES      = 64;
   localparam int unsigned LINE_WORDS = 4;
   localparam int unsigned ADDR_BITS  = 32;
   localparam int unsigned WORD_W     = 32;
   localparam int unsigned OFF_W      = $clog2(LINE_WORDS);
   localparam int unsigned IDX_W      = $clog2(LINES);
   localparam int unsigned TAG_W      = ADDR_BITS - IDX_W - OFF_W - 2;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [TAG_W-1:0]  tag_t;
   typedef logic [IDX_W-1:0]  idx_t;
   typedef logic [OFF_W-1:0]  off_t;

   localparam off_t LAST_BEAT = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WBACK = 2'd1,
      ST_FILL  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   typedef struct packed {
      logic                 cs;
      logic                 we;
      logic [ADDR_BITS-1:0] addr;
      word_t                data;
   } mem_req_t;

   typedef struct packed {
      logic  en;
      idx_t  idx;
      off_t  off;
      word_t data;
   } ram_wr_t;

   function automatic tag_t addr_tag(input logic [ADDR_BITS-1:0] a);
      return a[ADDR_BITS-1 -: TAG_W];
   endfunction

   function automatic idx_t addr_idx(input logic [ADDR_BITS-1:0] a);
      return a[OFF_W+2 +: IDX_W];
   endfunction

   function automatic off_t addr_off(input logic [ADDR_BITS-1:0] a);
      return a[2 +: OFF_W];
   endfunction

endpackage

// File: rtl/dcache_responder_data_ram.sv
// Cache storage: data words (one write port, two combinational reads) plus
// per-line tag/valid/dirty flops.
module dcache_data_ram
   import dcache_responder_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  ram_wr_t wr,
   input  logic    mark_dirty,
   input  logic    fill_done,
   input  tag_t    fill_tag,
   input  idx_t    rd_idx,
   input  off_t    rd_off,
   output word_t   rd_data,
   input  idx_t    wb_idx,
   input  off_t    wb_off,
   output word_t   wb_data,
   input  idx_t    lk_idx,
   output logic    lk_valid,
   output logic    lk_dirty,
   output tag_t    lk_tag
);

   word_t              data_q [LINES*LINE_WORDS];
   tag_t               tag_q  [LINES];
   logic [LINES-1:0]   valid_q;
   logic [LINES-1:0]   dirty_q;

   always_ff @(posedge clk) begin
      if (wr.en) data_q[{wr.idx, wr.off}] <= wr.data;
   end

   always_ff @(posedge clk) begin
      if (fill_done) tag_q[wr.idx] <= fill_tag;
   end

   // Line state: a completed refill installs a clean line; a store hit dirties it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         if (fill_done) begin
            valid_q[wr.idx] <= 1'b1;
            dirty_q[wr.idx] <= 1'b0;
         end
         if (mark_dirty) dirty_q[wr.idx] <= 1'b1;
      end
   end

   assign rd_data  = data_q[{rd_idx, rd_off}];
   assign wb_data  = data_q[{wb_idx, wb_off}];
   assign lk_valid = valid_q[lk_idx];
   assign lk_dirty = dirty_q[lk_idx];
   assign lk_tag   = tag_q[lk_idx];

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back, write-allocate data cache serving the MEM stage;
// misses run line write-back then refill on the main-memory port.
module dcache_responder
   import dcache_responder_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_ren,
   input  logic        cpu_wen,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_din,
   output logic [31:0] cpu_dout,
   output logic        cpu_stall,
   output logic        mem_cs,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_dout,
   input  logic [31:0] mem_din,
   input  logic        mem_ack,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);

   state_e   state_q, state_d;
   off_t     beat_q, beat_d;
   idx_t     miss_idx_q, miss_idx_d;
   tag_t     miss_tag_q, miss_tag_d;
   tag_t     victim_tag_q, victim_tag_d;
   logic     hit_inc, miss_inc;
   logic     mark_dirty, fill_done;
   ram_wr_t  ram_wr;
   mem_req_t mem_req;

   tag_t     cpu_tag;
   idx_t     cpu_idx;
   off_t     cpu_off;
   logic     req_c, hit_c;
   logic     lk_valid, lk_dirty;
   tag_t     lk_tag;
   word_t    rd_data, wb_data;
   logic     addr_lsb_unused;

   assign cpu_tag         = addr_tag(cpu_addr);
   assign cpu_idx         = addr_idx(cpu_addr);
   assign cpu_off         = addr_off(cpu_addr);
   assign addr_lsb_unused = ^cpu_addr[1:0];

   dcache_data_ram u_ram (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr         (ram_wr),
      .mark_dirty (mark_dirty),
      .fill_done  (fill_done),
      .fill_tag   (miss_tag_q),
      .rd_idx     (cpu_idx),
      .rd_off     (cpu_off),
      .rd_data    (rd_data),
      .wb_idx     (miss_idx_q),
      .wb_off     (beat_q),
      .wb_data    (wb_data),
      .lk_idx     (cpu_idx),
      .lk_valid   (lk_valid),
      .lk_dirty   (lk_dirty),
      .lk_tag     (lk_tag)
   );

   assign req_c     = cpu_ren | cpu_wen;
   assign hit_c     = req_c & lk_valid & (lk_tag == cpu_tag);
   assign cpu_stall = (req_c & ~hit_c) | (state_q != ST_IDLE);
   assign cpu_dout  = (cpu_ren & hit_c) ? rd_data : 32'd0;

   assign mem_cs    = mem_req.cs;
   assign mem_we    = mem_req.we;
   assign mem_addr  = mem_req.addr;
   assign mem_dout  = mem_req.data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         beat_q       <= '0;
         miss_idx_q   <= '0;
         miss_tag_q   <= '0;
         victim_tag_q <= '0;
         hit_cnt      <= 32'd0;
         miss_cnt     <= 32'd0;
      end else begin
         state_q      <= state_d;
         beat_q       <= beat_d;
         miss_idx_q   <= miss_idx_d;
         miss_tag_q   <= miss_tag_d;
         victim_tag_q <= victim_tag_d;
         if (hit_inc)  hit_cnt  <= hit_cnt + 32'd1;
         if (miss_inc) miss_cnt <= miss_cnt + 32'd1;
      end
   end

   // Miss sequencing; the latched index/tag govern the whole miss.
   always_comb begin
      state_d      = state_q;
      beat_d       = beat_q;
      miss_idx_d   = miss_idx_q;
      miss_tag_d   = miss_tag_q;
      victim_tag_d = victim_tag_q;
      hit_inc      = 1'b0;
      miss_inc     = 1'b0;
      mark_dirty   = 1'b0;
      fill_done    = 1'b0;
      ram_wr       = '0;
      mem_req      = '0;
      case (state_q)
         ST_IDLE: begin
            if (req_c && !hit_c) begin
               miss_idx_d   = cpu_idx;
               miss_tag_d   = cpu_tag;
               victim_tag_d = lk_tag;
               beat_d       = '0;
               miss_inc     = 1'b1;
               state_d      = (lk_valid && lk_dirty) ? ST_WBACK : ST_FILL;
            end else if (hit_c) begin
               hit_inc = 1'b1;
               if (cpu_wen) begin
                  ram_wr     = '{en: 1'b1, idx: cpu_idx, off: cpu_off, data: cpu_din};
                  mark_dirty = 1'b1;
               end
            end
         end
         ST_WBACK: begin
            mem_req = '{cs: 1'b1, we: 1'b1,
                        addr: {victim_tag_q, miss_idx_q, beat_q, 2'b00}, data: wb_data};
            if (mem_ack) begin
               beat_d = OFF_W'(beat_q + 1'b1);
               if (beat_q == LAST_BEAT) begin
                  beat_d  = '0;
                  state_d = ST_FILL;
               end
            end
         end
         ST_FILL: begin
            mem_req = '{cs: 1'b1, we: 1'b0,
                        addr: {miss_tag_q, miss_idx_q, beat_q, 2'b00}, data: 32'd0};
            if (mem_ack) begin
               ram_wr = '{en: 1'b1, idx: miss_idx_q, off: beat_q, data: mem_din};
               beat_d = OFF_W'(beat_q + 1'b1);
               if (beat_q == LAST_BEAT) begin
                  fill_done = 1'b1;
                  state_d   = ST_DONE;
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_dcache_responder.sv
// Scoreboard bench for dcache_responder: behavioural main memory with a
// two-cycle ack, expected beats and load data queued at stimulus time.
module tb_dcache_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_ren, cpu_wen;
   logic [31:0] cpu_addr, cpu_din;
   logic [31:0] cpu_dout;
   logic        cpu_stall;
   logic        mem_cs, mem_we;
   logic [31:0] mem_addr, mem_dout;
   logic [31:0] mem_din = 32'd0;
   logic        mem_ack = 1'b0;
   logic [31:0] hit_cnt, miss_cnt;

   typedef struct {
      bit        we;
      bit [31:0] addr;
      bit [31:0] data;
   } beat_t;

   beat_t     beat_q[$];
   bit [31:0] load_q[$];
   bit [31:0] wr_mem [bit [31:0]];
   bit [31:0] shadow [bit [31:0]];

   int        n_tests = 0;
   int        n_fail  = 0;
   int        beat_acks = 0;
   bit        hold = 1'b0;
   bit [31:0] exp_hit = 0, exp_miss = 0;

   always #5 clk = ~clk;

   dcache_responder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_ren   (cpu_ren),
      .cpu_wen   (cpu_wen),
      .cpu_addr  (cpu_addr),
      .cpu_din   (cpu_din),
      .cpu_dout  (cpu_dout),
      .cpu_stall (cpu_stall),
      .mem_cs    (mem_cs),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_dout  (mem_dout),
      .mem_din   (mem_din),
      .mem_ack   (mem_ack),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   function automatic bit [31:0] init_val(input bit [31:0] a);
      return (a * 32'h9E37_79B1) + 32'h0BAD_F00D;
   endfunction

   function automatic bit [31:0] mem_rd(input bit [31:0] a);
      if (wr_mem.exists(a)) return wr_mem[a];
      return init_val(a);
   endfunction

   function automatic bit [31:0] cur(input bit [31:0] a);
      if (shadow.exists(a)) return shadow[a];
      return init_val(a);
   endfunction

   // Main memory: ack two cycles into each beat, one cycle wide; beats scored here.
   always @(negedge clk) begin
      int cnt;
      beat_t e;
      if (mem_ack) begin
         mem_ack = 1'b0;
      end else if (!mem_cs) begin
         cnt = 0;
      end else if (!hold) begin
         cnt++;
         if (cnt >= 2) begin
            cnt = 0;
            mem_ack = 1'b1;
            beat_acks++;
            check_eq("beat_expected", {31'd0, beat_q.size() != 0}, 32'd1);
            if (beat_q.size() != 0) begin
               e = beat_q.pop_front();
               check_eq("beat_we", {31'd0, mem_we}, {31'd0, e.we});
               check_eq("beat_addr", mem_addr, e.addr);
               if (e.we) check_eq("beat_wdata", mem_dout, e.data);
            end
            if (mem_we) wr_mem[mem_addr] = mem_dout;
            else mem_din = mem_rd(mem_addr);
         end
      end
   end

   task automatic push_fill(input bit [31:0] base);
      for (int b = 0; b < 4; b++) beat_q.push_back('{we: 1'b0, addr: base + 32'(4*b), data: 32'd0});
   endtask

   task automatic push_wb(input bit [31:0] base);
      for (int b = 0; b < 4; b++)
         beat_q.push_back('{we: 1'b1, addr: base + 32'(4*b), data: cur(base + 32'(4*b))});
   endtask

   task automatic drive_req(input bit ren, input bit wen, input bit [31:0] addr, input bit [31:0] din);
      @(negedge clk);
      cpu_ren  = ren;
      cpu_wen  = wen;
      cpu_addr = addr;
      cpu_din  = din;
      if (wen) shadow[addr] = din;
      else if (ren) load_q.push_back(cur(addr));
      #1;
   endtask

   task automatic complete_req(input bit is_load, input bit exp_miss_f, input string tag);
      int  cyc = 0;
      bit  stalled = 1'b0;
      bit [31:0] e;
      while (cpu_stall && cyc < 400) begin
         stalled = 1'b1;
         @(negedge clk);
         #1;
         cyc++;
      end
      check_eq({tag, "_stall_timeout"}, {31'd0, cpu_stall}, 32'd0);
      check_eq({tag, "_stalled"}, {31'd0, stalled}, {31'd0, exp_miss_f});
      if (is_load) begin
         e = load_q.pop_front();
         check_eq({tag, "_dout"}, cpu_dout, e);
      end
      @(posedge clk);
      #1;
      cpu_ren = 1'b0;
      cpu_wen = 1'b0;
      if (exp_miss_f) exp_miss++;
      exp_hit++;
      check_eq({tag, "_beats_left"}, 32'(beat_q.size()), 32'd0);
      check_eq({tag, "_hit_cnt"}, hit_cnt, exp_hit);
      check_eq({tag, "_miss_cnt"}, miss_cnt, exp_miss);
   endtask

   task automatic access(input bit ren, input bit wen, input bit [31:0] addr,
                         input bit [31:0] din, input bit exp_miss_f, input string tag);
      drive_req(ren, wen, addr, din);
      complete_req(ren && !wen, exp_miss_f, tag);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit [31:0] a0;
      int        cyc;
      int        start;
      rst_n = 1'b0; cpu_ren = 1'b0; cpu_wen = 1'b0; cpu_addr = 32'd0; cpu_din = 32'd0;
      repeat (3) @(negedge clk);
      #1;
      check_eq("rst_stall", {31'd0, cpu_stall}, 32'd0);
      check_eq("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
      check_eq("rst_hit_cnt", hit_cnt, 32'd0);
      check_eq("rst_miss_cnt", miss_cnt, 32'd0);
      rst_n = 1'b1;
      @(negedge clk); #1;
      check_eq("idle_dout", cpu_dout, 32'd0);

      // T1: cold miss, refill, replay hit
      push_fill(32'h40);
      drive_req(1'b1, 1'b0, 32'h40, 32'd0);
      check_eq("t1_miss_stall", {31'd0, cpu_stall}, 32'd1);
      check_eq("t1_miss_dout", cpu_dout, 32'd0);
      complete_req(1'b1, 1'b1, "t1");

      // T2: store hit then load of the stored word
      access(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF, 1'b0, "t2_st");
      access(1'b1, 1'b0, 32'h44, 32'd0, 1'b0, "t2_ld");

      // T3: conflicting tag on dirty line 4 -> write-back then refill
      push_wb(32'h40);
      push_fill(32'h440);
      access(1'b1, 1'b0, 32'h440, 32'd0, 1'b1, "t3");

      // T4: memory holds ack low for 10 cycles during refill
      hold = 1'b1;
      push_fill(32'h1000);
      drive_req(1'b1, 1'b0, 32'h1000, 32'd0);
      cyc = 0;
      while (!mem_cs && cyc < 20) begin @(negedge clk); #1; cyc++; end
      a0 = mem_addr;
      check_eq("t4_first_addr", a0, 32'h1000);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         check_eq("t4_cs_hold", {31'd0, mem_cs}, 32'd1);
         check_eq("t4_addr_hold", mem_addr, a0);
         check_eq("t4_stall_hold", {31'd0, cpu_stall}, 32'd1);
      end
      hold = 1'b0;
      complete_req(1'b1, 1'b1, "t4");

      // T5: reset while write-back beat 2 is outstanding
      access(1'b0, 1'b1, 32'h440, 32'hCAFE_0440, 1'b0, "t5_st");
      push_wb(32'h440);
      push_fill(32'h40);
      drive_req(1'b1, 1'b0, 32'h40, 32'd0);
      void'(load_q.pop_back());
      start = beat_acks;
      cyc = 0;
      while ((beat_acks - start) < 2 && cyc < 100) begin @(negedge clk); #1; cyc++; end
      @(negedge clk); #1;
      check_eq("t5_pre_cs", {31'd0, mem_cs}, 32'd1);
      check_eq("t5_pre_addr", mem_addr, 32'h448);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("t5_rst_cs", {31'd0, mem_cs}, 32'd0);
      check_eq("t5_rst_we", {31'd0, mem_we}, 32'd0);
      check_eq("t5_rst_addr", mem_addr, 32'd0);
      check_eq("t5_rst_dout", mem_dout, 32'd0);
      check_eq("t5_rst_hit", hit_cnt, 32'd0);
      check_eq("t5_rst_miss", miss_cnt, 32'd0);
      beat_q.delete();
      cpu_ren = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_hit = 0;
      exp_miss = 0;
      push_fill(32'h40);
      access(1'b1, 1'b0, 32'h40, 32'd0, 1'b1, "t5_refill");
      access(1'b1, 1'b0, 32'h44, 32'd0, 1'b0, "t5_ld44");

      // T6: ren and wen together on a hit act as a store
      access(1'b1, 1'b1, 32'h48, 32'h1234_5678, 1'b0, "t6_st");
      access(1'b1, 1'b0, 32'h48, 32'd0, 1'b0, "t6_ld");

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
